// File: rtl/data_mem_pkg.sv
// Purpose: shared encodings and sizing constants for the data memory controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package data_mem_pkg;

    // Sizing for the default 32-bit build; the modules derive their own
    // lane counts from their DATA_W parameter.
    localparam int DATA_W_DFLT = 32;
    localparam int LANES       = DATA_W_DFLT / 8;
    localparam int LANE_W      = $clog2(LANES);

    // Access size encoding on req_size.
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Controller FSM: INIT clears memory one word per cycle, RUN serves requests.
    typedef logic [0:0] state_t;
    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/data_mem_lane_fmt.sv
// Purpose: byte-lane formatting; store byte enables / lane-shifted write data, load align + extend.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; follows its inputs.
// Ports: size/is_signed/lane describe the access; wdata is right-aligned store data;
//        rword is the addressed memory word; byte_en/wdata_sh feed the write port;
//        load_data is the right-aligned, extended load result.
module data_mem_lane_fmt
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NLW    = $clog2(DATA_W / 8)
) (
    input  logic [1:0]          size,
    input  logic                is_signed,
    input  logic [NLW-1:0]      lane,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rword,
    output logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   wdata_sh,
    output logic [DATA_W-1:0]   load_data
);
    localparam int NL = DATA_W / 8;

    logic [NLW+2:0]    sh_amt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep_mask;
    logic              ext_bit;

    // Lane index in bits: lane * 8.
    assign sh_amt   = {lane, 3'b000};
    assign wdata_sh = wdata << sh_amt;
    assign shifted  = rword >> sh_amt;

    always_comb begin
        byte_en   = '0;
        keep_mask = '1;
        ext_bit   = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en   = NL'(1) << lane;
                keep_mask = DATA_W'(8'hFF);
                ext_bit   = is_signed & shifted[7];
            end
            SZ_HALF: begin
                byte_en   = NL'(3) << lane;
                keep_mask = DATA_W'(16'hFFFF);
                ext_bit   = is_signed & shifted[15];
            end
            SZ_WORD: begin
                byte_en   = '1;
            end
            default: begin
                byte_en   = '0;
            end
        endcase
    end

    // Masked form of extension avoids zero-width replications at DATA_W=16.
    assign load_data = (shifted & keep_mask) | ({DATA_W{ext_bit}} & ~keep_mask);

endmodule

// File: rtl/data_mem_ctrl.sv
// Purpose: single-port data memory with byte/half/word access, cleared after every reset.
// Latency: 1 cycle from accept to rsp_valid; stores write at the accept edge.
// Backpressure: one-entry response stage; req_ready drops while a response is stalled.
// Ports: clk/rst (async active-high); req_* valid/ready request channel;
//        rsp_* valid/ready response channel (rdata right-aligned, err flag);
//        init_done high once the post-reset clear has finished.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int NL     = DATA_W / 8;
    localparam int NLW    = $clog2(NL);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WIDX_W = ADDR_W - NLW;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [NLW-1:0]    lane;
    logic [WIDX_W-1:0] widx;
    logic [IDX_W-1:0]  idx;
    logic              req_err;
    logic              accept;
    logic              store_en;
    logic [NL-1:0]     byte_en;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rword;
    logic [DATA_W-1:0] load_data;

    assign lane  = req_addr[NLW-1:0];
    assign widx  = req_addr[ADDR_W-1:NLW];
    assign idx   = widx[IDX_W-1:0];
    // Combinational read: a store at the previous edge is already visible.
    assign rword = mem[idx];

    // Any set bit above the in-range index field means word index >= DEPTH.
    assign req_err = (req_size == SZ_ILLEGAL)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (lane != '0))
                   || (|widx[WIDX_W-1:IDX_W]);

    assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign store_en  = accept && req_we && !req_err;

    data_mem_lane_fmt #(
        .DATA_W (DATA_W),
        .NLW    (NLW)
    ) u_lane_fmt (
        .size      (req_size),
        .is_signed (req_signed),
        .lane      (lane),
        .wdata     (req_wdata),
        .rword     (rword),
        .byte_en   (byte_en),
        .wdata_sh  (wdata_sh),
        .load_data (load_data)
    );

    // INIT walks the counter over every word once, then hands over to RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end else begin
                init_cnt_d = init_cnt_q + IDX_W'(1);
            end
        end
    end

    // Response register only changes on accept or on a consumed response,
    // so a stalled response holds its data and error flag.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_rdata_d = (req_err || req_we) ? '0 : load_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is not reset; INIT clears it after every reset instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[init_cnt_q] <= '0;
        end else if (store_en) begin
            for (int i = 0; i < NL; i++) begin
                if (byte_en[i]) begin
                    mem[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Purpose: self-checking bench for data_mem_ctrl against a byte-array reference model.
// Latency: checks 1-cycle response latency and exact init duration.
// Backpressure: exercises response stalls and back-to-back requests.
module tb_data_mem_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              req_valid  = 1'b0;
    logic              req_we     = 1'b0;
    logic [1:0]        req_size   = 2'b00;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr   = '0;
    logic [DATA_W-1:0] req_wdata  = '0;
    logic              rsp_ready  = 1'b1;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_b [0:DEPTH*4-1];

    data_mem_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: memory as little-endian bytes, access = 2^size bytes at addr.
    task automatic model_req(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int          nb;
        int          base;
        logic [63:0] v;
        nb      = 1 << sz;
        e.err   = (sz == 2'b11) || ((a % nb) != 0) || (a >= 32'(DEPTH * 4));
        e.rdata = '0;
        if (!e.err) begin
            base = int'(a);
            if (we) begin
                for (int i = 0; i < nb; i++) mem_b[base + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_b[base + i];
                if (sg && v[8*nb-1]) begin
                    for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                e.rdata = v[31:0];
            end
        end
    endtask

    // Compare process: every presented response against the model, every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH * 4; i++) mem_b[i] = 8'h00;
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    chk("model_rsp", 64'({rsp_err, rsp_rdata}),
                        64'({exp_q[0].err, exp_q[0].rdata}));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                model_req(req_we, req_size, req_signed, req_addr, req_wdata, e);
                exp_q.push_back(e);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        logic ok;
        ok         = 1'b0;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic op(input string nm, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
        issue(we, sz, sg, a, wd);
        chk({nm, "_vld"},  64'(rsp_valid), 64'(1));
        chk({nm, "_data"}, 64'(rsp_rdata), 64'(exp_d));
        chk({nm, "_err"},  64'(rsp_err),   64'(exp_e));
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({nm, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({nm, "_rsp_err"},   64'(rsp_err),   64'(0));
        chk({nm, "_init_done"}, 64'(init_done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected summary earlier", $time);
        $fatal(1);
    end

    initial begin
        int ncyc;

        // Reset state.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("init_busy_ready", 64'(req_ready), 64'(0));
        wait_init(ncyc);
        chk("init_cycles", 64'(ncyc), 64'(256));

        // Cleared memory, last word.
        op("ld_3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0000_0000, 1'b0);

        // Word store then narrow loads.
        op("st_w10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op("ldb_s13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
        op("ldh_u10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0);
        op("ldh_s12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
        op("ldb_u13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_00DE, 1'b0);

        // Byte store merges into one lane.
        op("st_b11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF5A, 32'h0, 1'b0);
        op("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);

        // Half store in the top lanes of the last word.
        op("st_h3fe", 1'b1, 2'b01, 1'b0, 32'h3FE, 32'h0000_1234, 32'h0, 1'b0);
        op("ld_w3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h1234_0000, 1'b0);

        // Error cases leave memory untouched.
        op("err_st_w12", 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op("chk1_w10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);
        op("err_ld_h11", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1);
        op("chk2_w10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);
        op("err_st_400", 1'b1, 2'b10, 1'b0, 32'h400, 32'h1234_5678, 32'h0, 1'b1);
        op("chk3_w10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);
        op("chk_w0",     1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
        op("err_sz11",   1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op("chk4_w10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);

        // Stalled response with a second load waiting.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        op("stall_a", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b1;
        req_addr   = 32'h13;
        req_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_req_ready", 64'(req_ready), 64'(0));
            chk("stall_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("stall_rdata",     64'(rsp_rdata), 64'(32'hDEAD_5AEF));
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        op("stall_b", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
        op("stall_c", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0);
        op("stall_d", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_005A, 1'b0);
        @(posedge clk);
        #1;
        chk("stall_drained", 64'(exp_q.size()), 64'(0));

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        op("pend", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        wait_init(ncyc);
        chk("reinit_cycles", 64'(ncyc), 64'(256));
        op("reinit_w10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 1'b0);
        op("reinit_w3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0000_0000, 1'b0);
        @(posedge clk);
        #1;
        chk("final_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
